// File: rtl/demux1to4_stream.sv
// 1:4 stream demultiplexer: one registered slot per output channel, with saturating per-channel transfer counters.
// Define DEMUX_BROADCAST_EN to add in_bcast, which loads a word into all four slots at once.
module demux1to4_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
`ifdef DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  input  logic             clr_cnt
);

  logic [3:0]       ready;
  logic [3:0]       open;
  logic [3:0]       acc;
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic             bcast;
  logic             accept;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign ready = {out3_ready, out2_ready,
                  out1_ready, out0_ready};

  // A slot can take a word if empty or draining this cycle
  assign open = ~valid_q | ready;

  always_comb begin
    in_ready = open[in_sel];
    if (bcast) in_ready = &open;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      acc[n]     = accept &
                   (bcast | (in_sel == 2'(n)));
      valid_d[n] = acc[n] |
                   (valid_q[n] & ~ready[n]);
      data_d[n]  = acc[n] ? in_data : data_q[n];
      cnt_d[n]   = cnt_q[n];
      if (clr_cnt)
        cnt_d[n] = '0;
      else if (acc[n] && cnt_q[n] != '1)
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= data_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
    end
  end

  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out2_valid = valid_q[2];
  assign out3_valid = valid_q[3];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];
  assign cnt2       = cnt_q[2];
  assign cnt3       = cnt_q[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Randomized and directed bench for demux1to4_stream.
// Reference model tracks per-channel slot contents and counts.
module tb_demux1to4_stream;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic          bcast;
  logic [3:0]    rdy;
  logic          clr_cnt;
  logic          o0v, o1v, o2v, o3v;
  logic [W-1:0]  o0d, o1d, o2d, o3d;
  logic [CW-1:0] c0, c1, c2, c3;

  logic [3:0]    ov;
  logic [W-1:0]  od [4];
  logic [CW-1:0] oc [4];

  bit            mv [4];
  logic [W-1:0]  md [4];
  int            mc [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux1to4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(bcast),
`endif
    .out0_valid(o0v), .out1_valid(o1v),
    .out2_valid(o2v), .out3_valid(o3v),
    .out0_ready(rdy[0]), .out1_ready(rdy[1]),
    .out2_ready(rdy[2]), .out3_ready(rdy[3]),
    .out0_data(o0d), .out1_data(o1d),
    .out2_data(o2d), .out3_data(o3d),
    .cnt0(c0), .cnt1(c1), .cnt2(c2), .cnt3(c3),
    .clr_cnt(clr_cnt)
  );

  assign ov = {o3v, o2v, o1v, o0v};
  assign od[0] = o0d;
  assign od[1] = o1d;
  assign od[2] = o2d;
  assign od[3] = o3d;
  assign oc[0] = c0;
  assign oc[1] = c1;
  assign oc[2] = c2;
  assign oc[3] = c3;

  // A channel can take a word when its slot is empty or being drained.
  function automatic bit m_ready();
    bit r;
    if (bcast) begin
      r = 1'b1;
      for (int n = 0; n < 4; n++)
        r = r && (!mv[n] || rdy[n]);
    end else begin
      r = !mv[in_sel] || rdy[in_sel];
    end
    return r;
  endfunction

  function automatic void m_reset();
    for (int n = 0; n < 4; n++) begin
      mv[n] = 0;
      md[n] = '0;
      mc[n] = 0;
    end
  endfunction

  // Advance one clock; the model applies the same cycle's inputs.
  task automatic tick();
    bit acc;
    bit hit;
    acc = in_valid && m_ready();
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      hit = acc && (bcast || in_sel == n);
      if (hit) begin
        mv[n] = 1;
        md[n] = in_data;
      end else if (mv[n] && rdy[n]) begin
        mv[n] = 0;
      end
      if (clr_cnt) mc[n] = 0;
      else if (hit && mc[n] < CMAX) mc[n]++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_sel = 0; in_data = 0;
    bcast = 0; rdy = 0; clr_cnt = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (ov !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0000", ov);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (od[n] !== '0 || oc[n] !== '0) begin
        n_fail++;
        $display("FAIL reset_state ch%0d data %h cnt %0d want 0",
                 n, od[n], oc[n]);
      end
      in_sel = 2'(n);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready sel%0d got %b want 1",
                 n, in_ready);
      end
    end
  endtask

  task automatic test_unicast();
    in_valid = 1; in_sel = 2; in_data = 4'hA; rdy = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL uni_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (ov !== 4'b0100 || o2d !== 4'hA || c2 !== 8'd1) begin
      n_fail++;
      $display("FAIL uni_first valid %b d2 %h c2 %0d want 0100 a 1",
               ov, o2d, c2);
    end
    in_data = 4'h5;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL uni_blocked got %b want 0", in_ready);
    end
    in_sel = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL uni_resel got %b want 1", in_ready);
    end
    tick();
    in_valid = 0;
    n_checks++;
    if (o1d !== 4'h5 || o2d !== 4'hA || ov !== 4'b0110) begin
      n_fail++;
      $display("FAIL uni_second d1 %h d2 %h v %b want 5 a 0110",
               o1d, o2d, ov);
    end
  endtask

  task automatic test_replace();
    int prev;
    in_valid = 1; in_sel = 3; in_data = 4'h3; rdy = 0;
    tick();
    prev = mc[3];
    rdy = 4'b1000; in_data = 4'hC;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL repl_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 0; rdy = 0;
    n_checks++;
    if (o3v !== 1'b1 || o3d !== 4'hC || c3 !== CW'(prev + 1)) begin
      n_fail++;
      $display("FAIL repl v %b d %h c %0d want 1 c %0d",
               o3v, o3d, c3, prev + 1);
    end
  endtask

  task automatic test_saturate();
    in_valid = 1; in_sel = 0; rdy = 4'hF;
    repeat (260) begin
      in_data = W'($urandom);
      tick();
    end
    n_checks++;
    if (c0 !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cnt0 got %0d want 255", c0);
    end
    clr_cnt = 1; in_data = 4'h7;
    tick();
    clr_cnt = 0; in_valid = 0;
    n_checks++;
    if (c0 !== 8'd0 || o0v !== 1'b1 || o0d !== 4'h7) begin
      n_fail++;
      $display("FAIL sat_clr c0 %0d v %b d %h want 0 1 7",
               c0, o0v, o0d);
    end
  endtask

  task automatic test_reset_mid();
    rdy = 0; in_valid = 1;
    in_sel = 0; in_data = 4'h6;
    tick();
    in_sel = 1; in_data = 4'hE;
    tick();
    in_valid = 0;
    n_checks++;
    if (ov[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL rmid_fill got %b want 11", ov[1:0]);
    end
    #2 rst = 1'b1;
    #1;
    m_reset();
    n_checks++;
    if (ov !== 4'b0000 || o0d !== '0 || o1d !== '0
        || c0 !== '0 || c1 !== '0) begin
      n_fail++;
      $display("FAIL rmid_clear v %b d0 %h d1 %h want 0",
               ov, o0d, o1d);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_sel = 2'(n);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rmid_ready sel%0d got %b want 1",
                 n, in_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      in_sel   = 2'($urandom);
      in_data  = W'($urandom);
      rdy      = 4'($urandom);
      clr_cnt  = ($urandom_range(0, 40) == 0);
      #1;
      n_checks++;
      if (in_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rnd_ready cyc %0d got %b want %b",
                 i, in_ready, m_ready());
      end
      tick();
      for (int n = 0; n < 4; n++) begin
        n_checks++;
        if (ov[n] !== mv[n] || (mv[n] && od[n] !== md[n])
            || oc[n] !== CW'(mc[n])) begin
          n_fail++;
          $display("FAIL rnd_ch%0d cyc %0d v %b d %h c %0d want %b %h %0d",
                   n, i, ov[n], od[n], oc[n], mv[n], md[n], mc[n]);
        end
      end
    end
    in_valid = 0; clr_cnt = 0; rdy = 0;
  endtask

`ifdef DEMUX_BROADCAST_EN
  task automatic test_bcast();
    in_valid = 0; rdy = 4'hF; clr_cnt = 1;
    tick();
    clr_cnt = 0; rdy = 0;
    in_valid = 1; in_sel = 1; in_data = 4'h2;
    tick();
    bcast = 1; in_data = 4'h9;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bc_blocked got %b want 0", in_ready);
    end
    rdy = 4'b0010;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bc_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 0; bcast = 0; rdy = 0;
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (ov[n] !== 1'b1 || od[n] !== 4'h9
          || oc[n] !== CW'(n == 1 ? 2 : 1)) begin
        n_fail++;
        $display("FAIL bc_ch%0d v %b d %h c %0d want 1 9 %0d",
                 n, ov[n], od[n], oc[n], n == 1 ? 2 : 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unicast();
    test_replace();
    test_saturate();
    test_reset_mid();
    test_random();
`ifdef DEMUX_BROADCAST_EN
    test_bcast();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- Companion to the 4:1 select mux: routes one input stream to one of four output channels chosen by a 2-bit select.
- Each output channel has a single-entry registered holding slot and a valid/ready handshake, so the four consumers backpressure independently.
- Per-channel saturating transfer counters support bring-up and IFT test benches.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of input and every output channel
- CNT_W, 8, width of each per-channel transfer counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  2  destination channel: 00 to 11 select out0 to out3
- in_data  input  WIDTH  payload
- out0_valid, out1_valid, out2_valid, out3_valid  output  1 each  channel slot holds a word
- out0_ready, out1_ready, out2_ready, out3_ready  input  1 each  consumer takes the word
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  channel payload (registered)
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  accepted-word count per channel
- clr_cnt  input  1  synchronous clear of all counters

Behaviour:
- Reset (async assert, sync release): all outN_valid = 0, outN_data = 0, cntN = 0. in_ready then follows its combinational rule.
- Channel slot state per channel: EMPTY or FULL.
  - EMPTY -> FULL on accept to that channel.
  - FULL -> EMPTY on outN_valid & outN_ready with no new accept.
  - FULL -> FULL (data replaced) on simultaneous drain and accept.
- in_ready is combinational: = !full[in_sel] | outN_ready[in_sel]. It depends only on the selected channel.
- Accept = in_valid & in_ready. The word appears on out[in_sel]_data with valid = 1 exactly 1 cycle later. Latency 1, throughput 1 word/cycle per channel.
- Non-selected channels are unaffected by an accept. Each holds its data and valid until drained.
- outN_data changes only on accept to channel N. It is stable while outN_valid = 1 and outN_ready = 0.
- in_sel and in_data are sampled only on accept. Changing in_sel while in_valid = 1 and in_ready = 0 is legal; in_ready re-evaluates for the new channel.
- Counters:
  - cntN increments by 1 on each accept to channel N.
  - Saturates at 2^CNT_W - 1 (no wrap).
  - clr_cnt = 1 forces all counters to 0 next cycle and has priority over an increment in the same cycle.
- Reset mid-operation: stored words are discarded, with no output valid after reset.
- No X propagation: outN_data holds its last value, never X, after the first reset.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN
- Defined:
  - Extra port in_bcast (input, 1 bit).
  - When in_bcast = 1, in_sel is ignored and in_ready = AND over all N of (!fullN | outN_ready).
  - An accept loads in_data into all four slots and increments all four counters.
  - Unicast behaviour is unchanged.
- Undefined: no in_bcast port; unicast only.

Test Plan:
- Reset, then in_sel = 2, in_data = 0xA, in_valid 1 cycle, all outN_ready = 0 -> next cycle out2_valid = 1, out2_data = 0xA, others valid = 0, cnt2 = 1.
- out2 FULL with out2_ready = 0, second word 0x5 to sel 2 -> in_ready = 0. Then sel 1 with 0x5 -> in_ready = 1, out1_data = 0x5; out2_data stays 0xA.
- out3 FULL, out3_ready = 1, simultaneous accept of 0xC to sel 3 -> out3_valid stays 1, data 0xC next cycle, cnt3 += 1.
- 260 accepts to sel 0 with CNT_W = 8 -> cnt0 = 255. Then clr_cnt together with an accept -> cnt0 = 0.
- Assert rst mid-stream with out0 and out1 FULL -> immediately all valids = 0 and data = 0; after release, in_ready = 1 for every sel.
- DEMUX_BROADCAST_EN defined, in_bcast = 1, data 0x9, out1 FULL and not ready -> in_ready = 0. After out1 drains -> accept; all four outputs = 0x9, all counters += 1.
